// File: rtl/dp_share_pkg.sv
// Shared types for the dp_share arbiter: FSM states, in-flight tag and index-width helper.
package dp_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Wide enough for the largest supported requester count (8).
  localparam int unsigned IDX_W_MAX = 3;

  typedef struct packed {
    logic                 valid;
    logic [IDX_W_MAX-1:0] idx;
  } tag_t;

  function automatic int unsigned idx_w(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/dp_share_arbiter_if.sv
// Requester, datapath and flush signals of dp_share_arbiter; master = environment, slave = arbiter.
interface dp_share_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               dp_in_valid;
  logic [DW-1:0]      dp_in_data;
  logic [DW-1:0]      dp_out_data;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               flush;
  logic               flush_done;

  modport master (
    output req_valid, req_last, req_data, dp_out_data, flush,
    input  req_ready, dp_in_valid, dp_in_data, rsp_valid, rsp_data, flush_done
  );

  modport slave (
    input  req_valid, req_last, req_data, dp_out_data, flush,
    output req_ready, dp_in_valid, dp_in_data, rsp_valid, rsp_data, flush_done
  );
endinterface

// File: rtl/dp_share_tag_pipe.sv
// Fixed-depth shift register of {valid, idx} tags tracking beats inside the shared datapath.
module dp_share_tag_pipe
  import dp_share_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAP   = DEPTH - 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t i_tag,
  output tag_t o_tag,
  output logic o_tap_valid,
  output logic o_empty
);

  logic [DEPTH-1:0]     r_valid;
  logic [IDX_W_MAX-1:0] r_idx [DEPTH];

  // Only the valid bits need clearing; idx is don't-care while its valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_tag.valid;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        r_valid[s] <= r_valid[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_idx[0] <= i_tag.idx;
    for (int unsigned s = 1; s < DEPTH; s++) begin
      r_idx[s] <= r_idx[s-1];
    end
  end

  assign o_tag.valid = r_valid[DEPTH-1];
  assign o_tag.idx   = r_idx[DEPTH-1];
  assign o_tap_valid = r_valid[TAP];
  assign o_empty     = ~|r_valid;

endmodule

// File: rtl/dp_share_arbiter.sv
// Round-robin, burst-locking front end sharing one fixed-latency datapath among NREQ requesters.
// Define DP_SHARE_RETIME_EN to register the response outputs (response latency LAT+1).
module dp_share_arbiter
  import dp_share_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned LAT       = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst_n,
  dp_share_arbiter_if.slave bus
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);
`ifdef DP_SHARE_RETIME_EN
  localparam int unsigned DEPTH = LAT + 1;
`else
  localparam int unsigned DEPTH = LAT;
`endif

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return IW'((32'(i) + 32'd1) % NREQ);
  endfunction

  state_e          r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [IW-1:0]   r_owner, w_owner_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [IW-1:0]   w_rr_idx, w_cand, w_sel;
  logic            w_rr_found, w_xfer;
  tag_t            w_tag_in, w_tag_out;
  logic            w_tap_valid, w_pipe_empty;
  logic [NREQ-1:0] w_rsp_valid;
  logic [DW-1:0]   r_rsp_data;

  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_cand     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = IW'((32'(r_ptr) + k) % NREQ);
      if (!w_rr_found && bus.req_valid[w_cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_count_nxt = r_count;
    w_xfer      = 1'b0;
    w_sel       = r_owner;
    case (r_state)
      IDLE: begin
        if (w_rr_found) begin
          w_xfer      = 1'b1;
          w_sel       = w_rr_idx;
          w_owner_nxt = w_rr_idx;
          w_count_nxt = CW'(1);
          if (bus.req_last[w_rr_idx] || (MAX_BURST == 1)) begin
            w_ptr_nxt = next_idx(w_rr_idx);
          end else begin
            w_state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.req_valid[r_owner]) begin
          w_xfer      = 1'b1;
          w_count_nxt = r_count + CW'(1);
          if (bus.req_last[r_owner] || ((32'(r_count) + 32'd1) == MAX_BURST)) begin
            w_ptr_nxt   = next_idx(r_owner);
            w_state_nxt = IDLE;
          end
        end else begin
          w_ptr_nxt   = next_idx(r_owner);
          w_state_nxt = IDLE;
        end
      end
      FLUSH: begin
        if (w_pipe_empty) begin
          w_ptr_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // The beat granted in the flush cycle still goes through; arbitration stops after it.
    if (bus.flush && (r_state != FLUSH)) begin
      w_state_nxt = FLUSH;
    end
    if (!rst_n) begin
      w_xfer = 1'b0;
    end
  end

  assign bus.req_ready   = w_xfer ? (NREQ'(1) << w_sel) : '0;
  assign bus.dp_in_valid = w_xfer;
  assign bus.dp_in_data  = w_xfer ? bus.req_data[w_sel*DW +: DW] : '0;
  assign bus.flush_done  = (r_state == FLUSH) && w_pipe_empty;

  assign w_tag_in.valid = w_xfer;
  assign w_tag_in.idx   = IDX_W_MAX'(w_sel);

  dp_share_tag_pipe #(
    .DEPTH (DEPTH),
    .TAP   (LAT - 1)
  ) u_tag_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_tag       (w_tag_in),
    .o_tag       (w_tag_out),
    .o_tap_valid (w_tap_valid),
    .o_empty     (w_pipe_empty)
  );

  always_comb begin
    w_rsp_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_rsp_valid[i] = w_tag_out.valid && (w_tag_out.idx == IDX_W_MAX'(i));
    end
  end

  assign bus.rsp_valid = w_rsp_valid;

`ifdef DP_SHARE_RETIME_EN
  // Tap sits one stage ahead of the pipe output so data and strobe leave the same flop edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
    end else if (w_tap_valid) begin
      r_rsp_data <= bus.dp_out_data;
    end
  end

  assign bus.rsp_data = r_rsp_data;
`else
  logic [DW-1:0] w_rsp_data;

  assign w_rsp_data   = w_tap_valid ? bus.dp_out_data : r_rsp_data;
  assign bus.rsp_data = w_rsp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
    end else begin
      r_rsp_data <= w_rsp_data;
    end
  end
`endif

endmodule

// File: tb/tb_dp_share_arbiter.sv
// Self-checking bench for dp_share_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_dp_share_arbiter;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int LAT       = 2;
  localparam int MAX_BURST = 4;
`ifdef DP_SHARE_RETIME_EN
  localparam int RSP_LAT = LAT + 1;
`else
  localparam int RSP_LAT = LAT;
`endif

  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] dat;
  } rsp_t;

  logic clk;
  logic rst_n;
  logic [DW-1:0] key;
  logic [DW-1:0] dp_pipe [LAT];

  dp_share_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  dp_share_arbiter #(
    .NREQ      (NREQ),
    .DW        (DW),
    .LAT       (LAT),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in datapath: LAT register stages applying a reversible transform.
  always @(posedge clk) begin
    dp_pipe[0] <= bus.dp_in_data ^ key;
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign bus.dp_out_data = dp_pipe[LAT-1];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: rotation pointer, locked burst owner (-1 = none), beats so far, flush pending.
  int            m_ptr   = 0;
  int            m_owner = -1;
  int            m_beats = 0;
  bit            m_flush = 1'b0;
  logic [DW-1:0] m_last  = '0;
  rsp_t          q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ptr   = 0;
    m_owner = -1;
    m_beats = 0;
    m_flush = 1'b0;
    m_last  = '0;
  endtask

  task automatic eval(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                      input logic [NREQ*DW-1:0] d, input logic f);
    int              g;
    logic [NREQ-1:0] e_ready, e_rv;
    logic            e_dv, e_fd;
    logic [DW-1:0]   e_dd, e_rd;
    rsp_t            r;

    e_fd = m_flush && (q.size() == 0);

    e_rv = '0;
    e_rd = m_last;
    if (q.size() > 0 && q[0].due == cyc) begin
      r      = q.pop_front();
      e_rv   = NREQ'(1) << r.idx;
      e_rd   = r.dat;
      m_last = r.dat;
    end

    g = -1;
    if (!m_flush) begin
      if (m_owner >= 0) begin
        if (v[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    e_ready = (g >= 0) ? NREQ'(1) << g : '0;
    e_dv    = (g >= 0);
    e_dd    = (g >= 0) ? d[g*DW +: DW] : '0;

    chk("req_ready",   bus.req_ready,   e_ready);
    chk("dp_in_valid", bus.dp_in_valid, e_dv);
    chk("dp_in_data",  bus.dp_in_data,  e_dd);
    chk("rsp_valid",   bus.rsp_valid,   e_rv);
    chk("rsp_data",    bus.rsp_data,    e_rd);
    chk("flush_done",  bus.flush_done,  e_fd);

    if (m_flush) begin
      if (e_fd) begin
        m_flush = 1'b0;
        m_ptr   = 0;
        m_owner = -1;
      end
    end else begin
      if (g >= 0) begin
        if (m_owner < 0) m_beats = 0;
        m_beats++;
        q.push_back('{due: cyc + RSP_LAT, idx: g, dat: d[g*DW +: DW] ^ key});
        if (l[g] || m_beats == MAX_BURST) begin
          m_ptr   = (g + 1) % NREQ;
          m_owner = -1;
        end else begin
          m_owner = g;
        end
      end else if (m_owner >= 0) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
      if (f) begin
        m_flush = 1'b1;
        m_owner = -1;
      end
    end
  endtask

  // One clock: drive just after the rising edge, check at the falling edge.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                      input logic [NREQ*DW-1:0] d, input logic f);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.flush     = f;
    @(negedge clk);
    eval(v, l, d, f);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (q.size() > 0 || m_flush); n++) step('0, '0, '0, 1'b0);
    chk("drain_bound", 32'(q.size() == 0 && !m_flush), 32'd1);
  endtask

  function automatic logic [NREQ*DW-1:0] rnd_data();
    logic [NREQ*DW-1:0] d;
    for (int i = 0; i < NREQ; i++) d[i*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ*DW-1:0] d;
    logic [NREQ-1:0]    v, l;

    rst_n         = 1'b0;
    key           = '0;
    bus.req_valid = '1;
    bus.req_last  = '0;
    bus.req_data  = '1;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready",   bus.req_ready,   '0);
    chk("rst_dp_in_valid", bus.dp_in_valid, '0);
    chk("rst_dp_in_data",  bus.dp_in_data,  '0);
    chk("rst_rsp_valid",   bus.rsp_valid,   '0);
    chk("rst_rsp_data",    bus.rsp_data,    '0);
    chk("rst_flush_done",  bus.flush_done,  '0);
    rst_n = 1'b1;
    idle(1);

    // Single beat from requester 2, echo datapath.
    d = '0;
    d[2*DW +: DW] = 8'h5A;
    step(4'b0100, 4'b0100, d, 1'b0);
    idle(RSP_LAT + 1);

    // Rotation with all requesters valid and last on every beat (starts at 3).
    repeat (8) step('1, '1, rnd_data(), 1'b0);
    idle(RSP_LAT + 1);

    // Burst cap: move pointer to 1, then requesters 0 and 1 never assert last.
    step(4'b0001, 4'b0001, rnd_data(), 1'b0);
    repeat (7) step(4'b0011, 4'b0000, rnd_data(), 1'b0);
    idle(RSP_LAT + 1);

    // Flush with beats in flight; requests during flush must be ignored.
    step('1, '1, rnd_data(), 1'b0);
    step('1, 4'b0000, rnd_data(), 1'b1);
    step('1, '1, rnd_data(), 1'b1);
    step('1, '1, rnd_data(), 1'b0);
    drain();

    // Flush from idle with an empty pipe, then a repeated pulse while done.
    step('0, '0, '0, 1'b1);
    step('0, '0, '0, 1'b1);
    idle(1);
    step(4'b1000, 4'b1000, rnd_data(), 1'b0);
    idle(RSP_LAT + 1);

    // Random traffic through a non-trivial datapath transform.
    key = 8'hC3;
    for (int n = 0; n < 400; n++) begin
      v = NREQ'($urandom) | NREQ'($urandom);
      l = NREQ'($urandom) & NREQ'($urandom);
      step(v, l, rnd_data(), ($urandom_range(0, 39) == 0));
    end
    drain();

    // Reset one cycle after a transfer: in-flight response must vanish.
    step(4'b0010, 4'b0010, rnd_data(), 1'b0);
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_last  = '1;
    bus.flush     = 1'b0;
    #1;
    chk("mid_rst_req_ready",   bus.req_ready,   '0);
    chk("mid_rst_dp_in_valid", bus.dp_in_valid, '0);
    chk("mid_rst_dp_in_data",  bus.dp_in_data,  '0);
    chk("mid_rst_rsp_valid",   bus.rsp_valid,   '0);
    chk("mid_rst_rsp_data",    bus.rsp_data,    '0);
    chk("mid_rst_flush_done",  bus.flush_done,  '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cyc   = cyc + 2;
    rst_n = 1'b1;
    idle(RSP_LAT + 2);
    step(4'b1100, 4'b1100, rnd_data(), 1'b0);
    idle(RSP_LAT + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
